// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: runs the product motor, then pays out change coin by coin
// through an eject/sense hopper handshake. Define DISPENSE_RETRY_EN for one re-eject per coin.
module vend_dispense_ctrl #(
  parameter int COIN_VALUE    = 5,
  parameter int AMT_W         = 4,
  parameter int MOTOR_CYCLES  = 8,
  parameter int SENSE_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             vend,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             coin_sensed,
  output logic             busy,
  output logic             motor_on,
  output logic             hopper_eject,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] residue
);

  localparam int CNT_MAX = (MOTOR_CYCLES > SENSE_TIMEOUT) ? MOTOR_CYCLES : SENSE_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MOTOR_LAST   = CNT_W'(MOTOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(SENSE_TIMEOUT - 1);
  localparam logic [AMT_W-1:0] COIN_AMT     = AMT_W'(COIN_VALUE);

  typedef enum logic [2:0] {
    S_IDLE, S_MOTOR, S_CHANGE, S_EJECT, S_WAIT, S_DONE, S_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] residue_q, residue_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef DISPENSE_RETRY_EN
  logic             retry_q, retry_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      residue_q <= '0;
      cnt_q     <= '0;
`ifdef DISPENSE_RETRY_EN
      retry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      residue_q <= residue_d;
      cnt_q     <= cnt_d;
`ifdef DISPENSE_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    residue_d    = residue_q;
    cnt_d        = cnt_q;
`ifdef DISPENSE_RETRY_EN
    retry_d      = retry_q;
`endif
    busy         = (state_q != S_IDLE);
    motor_on     = (state_q == S_MOTOR);
    hopper_eject = (state_q == S_EJECT);
    done         = (state_q == S_DONE);
    fault        = (state_q == S_FAULT);

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          rem_d   = change_amt;
          cnt_d   = '0;
`ifdef DISPENSE_RETRY_EN
          retry_d = 1'b0;
`endif
          state_d = vend ? S_MOTOR : S_CHANGE;
        end
      end
      S_MOTOR: begin
        if (cnt_q == MOTOR_LAST) begin
          cnt_d   = '0;
          state_d = S_CHANGE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHANGE: begin
        // Whatever cannot be paid in whole coins is left as the residue.
        if (rem_q >= COIN_AMT) begin
          state_d = S_EJECT;
        end else begin
          residue_d = rem_q;
          state_d   = S_DONE;
        end
      end
      S_EJECT: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A sense on the final allowed cycle still counts as a paid coin.
        if (coin_sensed) begin
          rem_d   = rem_q - COIN_AMT;
`ifdef DISPENSE_RETRY_EN
          retry_d = 1'b0;
`endif
          state_d = S_CHANGE;
        end else if (cnt_q == TIMEOUT_LAST) begin
`ifdef DISPENSE_RETRY_EN
          if (!retry_q) begin
            retry_d = 1'b1;
            state_d = S_EJECT;
          end else begin
            state_d = S_FAULT;
          end
`else
          state_d = S_FAULT;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  assign residue = residue_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Randomized scoreboard bench for vend_dispense_ctrl; a hopper model answers each
// eject from a planned delay list. Honours DISPENSE_RETRY_EN like the design.
module tb_vend_dispense_ctrl;
  localparam int COIN     = 5;
  localparam int AMT_W    = 4;
  localparam int MOTOR    = 8;
  localparam int TMO      = 16;
  localparam int NO_SENSE = 99;
`ifdef DISPENSE_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req = 1'b0;
  logic             vend = 1'b0;
  logic [AMT_W-1:0] change_amt = '0;
  logic             sense_drv = 1'b0;
  logic             sense_spur = 1'b0;
  logic             coin_sensed;
  logic             busy, motor_on, hopper_eject, done, fault;
  logic [AMT_W-1:0] residue;

  assign coin_sensed = sense_drv | sense_spur;

  vend_dispense_ctrl #(
    .COIN_VALUE(COIN), .AMT_W(AMT_W), .MOTOR_CYCLES(MOTOR), .SENSE_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .vend(vend), .change_amt(change_amt),
    .coin_sensed(coin_sensed), .busy(busy), .motor_on(motor_on),
    .hopper_eject(hopper_eject), .done(done), .fault(fault), .residue(residue)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_fault;
    int offset;
    int motors;
    int ejects;
    int resid;
    int vend;
    int amt;
  } exp_t;

  exp_t sb_q[$];
  int   drv_q[$];
  int   cand_q[$];
  int   errors = 0;
  int   checks = 0;
  int   resid_model = 0;
  int   txn_id = 0;

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Hopper model: answers each eject after its planned delay, or stays silent.
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (hopper_eject) begin
        chk("eject_planned", int'(drv_q.size() > 0), 1);
        if (drv_q.size() > 0) begin
          d = drv_q.pop_front();
          if (d <= TMO) begin
            repeat (d) @(posedge clk);
            #1 sense_drv = 1'b1;
            @(posedge clk);
            #1 sense_drv = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: measures each busy span and scores it on done or fault rise.
  initial begin
    int   off, mc, ec;
    bit   busy_prev, fault_prev, after_done;
    exp_t e;
    off = 0; mc = 0; ec = 0;
    busy_prev = 1'b0; fault_prev = 1'b0; after_done = 1'b0;
    forever begin
      @(negedge clk);
      if (after_done) begin
        chk("busy_after_done", int'(busy), 0);
        after_done = 1'b0;
      end
      if (busy && !busy_prev) begin
        off = 0; mc = 0; ec = 0;
      end else if (busy) begin
        off++;
      end
      if (busy) begin
        mc += int'(motor_on);
        ec += int'(hopper_eject);
      end
      if (done || (fault && !fault_prev)) begin
        chk("sb_has_entry", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          txn_id++;
          $display("txn %0d: vend=%0d amt=%0d end=%s offset=%0d motor=%0d eject=%0d residue=%0d",
                   txn_id, e.vend, e.amt, fault ? "fault" : "done", off, mc, ec, residue);
          chk("end_kind", int'(fault), int'(e.is_fault));
          chk("end_offset", off, e.offset);
          chk("motor_cycles", mc, e.motors);
          chk("eject_pulses", ec, e.ejects);
          chk("residue", int'(residue), e.resid);
        end
        if (done) after_done = 1'b1;
      end
      busy_prev  = busy;
      fault_prev = fault;
    end
  end

  task automatic reset_and_check();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    drv_q.delete();
    resid_model = 0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_motor_on", int'(motor_on), 0);
    chk("rst_hopper_eject", int'(hopper_eject), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_residue", int'(residue), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) chk("idle_timeout", 1, 0);
  endtask

  // Reference: coins = amt / COIN, each attempt costs one eject cycle plus its wait.
  task automatic run_txn(input bit v, input int amt);
    exp_t e;
    int   t, d, att, n;
    bit   failed;
    t = v ? MOTOR : 0;
    failed = 1'b0;
    e.motors = v ? MOTOR : 0;
    e.ejects = 0;
    for (int ci = 0; ci < amt / COIN && !failed; ci++) begin
      t += 1;
      att = 0;
      forever begin
        d = (cand_q.size() > 0) ? cand_q.pop_front() : 3;
        drv_q.push_back(d);
        e.ejects++;
        att++;
        if (d <= TMO) begin
          t += 1 + d;
          break;
        end
        t += 1 + TMO;
        if (!RETRY || att == 2) begin
          failed = 1'b1;
          break;
        end
      end
    end
    if (!failed) begin
      t += 1;
      resid_model = amt % COIN;
    end
    e.is_fault = failed;
    e.offset   = t;
    e.resid    = resid_model;
    e.vend     = int'(v);
    e.amt      = amt;
    cand_q.delete();

    wait_idle();
    sb_q.push_back(e);
    req = 1'b1;
    vend = v;
    change_amt = AMT_W'(amt);
    @(posedge clk);
    // A conflicting request while busy must be ignored.
    #1 vend = ~v;
    change_amt = ~change_amt;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 req = 1'b0;

    n = 0;
    @(negedge clk);
    while (busy && !fault && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) begin
      chk("txn_timeout", 1, 0);
      sb_q.delete();
      reset_and_check();
    end else if (fault) begin
      repeat (4) @(negedge clk);
      chk("fault_sticky", int'(fault), 1);
      chk("fault_busy", int'(busy), 1);
      chk("fault_motor_off", int'(motor_on), 0);
      chk("fault_eject_off", int'(hopper_eject), 0);
      chk("fault_no_done", int'(done), 0);
      reset_and_check();
    end
  endtask

  initial begin
    int r;
    repeat (3) @(posedge clk);
    reset_and_check();

    @(negedge clk) sense_spur = 1'b1;
    @(negedge clk) sense_spur = 1'b0;
    repeat (2) @(negedge clk);
    chk("spur_busy", int'(busy), 0);
    chk("spur_eject", int'(hopper_eject), 0);

    run_txn(1'b1, 0);
    cand_q = '{3, 3};
    run_txn(1'b0, 10);
    cand_q = '{3};
    run_txn(1'b1, 7);
    cand_q = '{16};
    run_txn(1'b0, 5);
    cand_q = '{NO_SENSE, NO_SENSE};
    run_txn(1'b0, 5);
    cand_q = '{1, 16, 2};
    run_txn(1'b0, 15);
    run_txn(1'b0, 3);
    cand_q = '{NO_SENSE, 4, 2};
    run_txn(1'b1, 9);

    wait_idle();
    req = 1'b1;
    vend = 1'b1;
    change_amt = 4'd15;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_motor_on", int'(motor_on), 1);
    reset_and_check();
    run_txn(1'b0, 4);

    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < 8; j++) begin
        r = int'($urandom_range(19, 0));
        cand_q.push_back(r == 0 ? NO_SENSE : (r == 1 ? TMO : int'($urandom_range(TMO - 1, 1))));
      end
      run_txn(1'($urandom_range(1, 0)), int'($urandom_range(15, 0)));
    end

    wait_idle();
    repeat (2) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1);
  end

endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
- Consumer side of the vending FSM's vend/change outputs.
- Takes one dispense request (product flag plus change amount in $1 units) and runs the product motor for a fixed time.
- Then ejects change one coin at a time through a coin hopper, using an eject/sense handshake with timeout.
- Reports completion or a sticky fault to the front-end FSM.

Parameters:
- COIN_VALUE, 5, value in $1 of one hopper coin.
- AMT_W, 4, width of change_amt.
- MOTOR_CYCLES, 8, cycles motor_on is held high per product (must be ≥1).
- SENSE_TIMEOUT, 16, maximum cycles to wait for coin_sensed after an eject pulse.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  dispense request; accepted only when busy=0.
- vend  input  1  1 = dispense one product for this request.
- change_amt  input  AMT_W  change owed in $1 units, sampled with req.
- coin_sensed  input  1  hopper exit sensor, 1-cycle pulse per coin ejected.
- busy  output  1  high from the cycle after acceptance until return to IDLE.
- motor_on  output  1  product motor drive.
- hopper_eject  output  1  1-cycle pulse, ejects one coin.
- done  output  1  1-cycle pulse, request completed successfully.
- fault  output  1  sticky hopper fault.
- residue  output  AMT_W  change_amt mod COIN_VALUE from the last accepted request (undispensable remainder).

Behaviour:
- Reset: state=IDLE; busy, motor_on, hopper_eject, done, fault=0; residue=0; internal remaining and counters cleared. Reset overrides every state, including mid-dispense and FAULT.
- Acceptance: req=1 in IDLE registers vend and change_amt at that edge. req is ignored in any other state; there is no queueing.
- States:
  - IDLE: go to MOTOR if captured vend=1; else to CHANGE.
  - MOTOR: motor_on=1 for exactly MOTOR_CYCLES consecutive cycles, then CHANGE.
  - CHANGE: if remaining ≥ COIN_VALUE go to EJECT; else go to DONE.
  - EJECT: hopper_eject=1 for exactly one cycle, clear the timeout counter, then WAIT.
  - WAIT:
    - coin_sensed=1: remaining -= COIN_VALUE, go to CHANGE.
    - Counter reaches SENSE_TIMEOUT with no sense: go to FAULT.
  - DONE: done=1 for one cycle, then IDLE.
  - FAULT: fault=1 and busy=1 held until reset. motor_on and hopper_eject stay 0.
- Remaining change is computed by repeated subtraction; no divider. residue = remaining value when CHANGE exits to DONE.
- Latency: with req accepted at edge N, the first cycle of motor_on or the first state after IDLE is N+1. busy=0 again in the cycle after done.
- coin_sensed outside WAIT: ignored; it does not decrement remaining.
- coin_sensed in the same cycle as the timeout limit: the sense wins, no fault.
- Zero-work request (vend=0, change_amt<COIN_VALUE): IDLE→CHANGE→DONE, done 2 cycles after acceptance, no motor, no eject.
- change_amt all-ones (15) with COIN_VALUE=5: exactly 3 ejects, residue=0.

Optional Feature:
- Macro: DISPENSE_RETRY_EN.
- Defined: the first timeout for a given coin returns to EJECT once (a second eject pulse with a fresh timeout). A second timeout for the same coin goes to FAULT. The retry flag clears on each successful sense.
- Undefined: the first timeout goes directly to FAULT.

Test Plan:
- Reset, then req vend=1 change_amt=0 → motor_on high exactly 8 cycles, no hopper_eject, done pulse once, busy low the cycle after done, residue=0.
- req vend=0 change_amt=10, coin_sensed returned 3 cycles after each eject → exactly 2 hopper_eject pulses, done once, residue=0.
- req vend=1 change_amt=7 → 8 motor cycles, 1 eject, done, residue=2. A second req while busy=1 produces no effect.
- req change_amt=5 with no coin_sensed:
  - Macro undefined: fault rises 16 cycles after WAIT entry and stays high; done is never asserted.
  - Macro defined: a second eject is issued and fault rises only after the second timeout.
- Edge cases:
  - coin_sensed asserted exactly at timeout cycle 16 → no fault, done.
  - Spurious coin_sensed in IDLE → ignored.
  - reset asserted mid-MOTOR → all outputs 0 next cycle, state IDLE.
